// File: rtl/memory_responder_if.sv
// Datapath-to-memory port: request (MAR address, write data, read/write strobes)
// and the responder's read data, busy, done and error status.
interface memory_responder_if #(
  parameter int WIDTH = 32
) ();
  logic [31:0]      mar_addr;
  logic [WIDTH-1:0] mem_wdata;
  logic             mem_read;
  logic             mem_write;
  logic [WIDTH-1:0] mem_rdata;
  logic             mem_busy;
  logic             mem_done;
  logic             mem_err;

  modport master (
    output mar_addr, mem_wdata, mem_read, mem_write,
    input  mem_rdata, mem_busy, mem_done, mem_err
  );

  modport slave (
    input  mar_addr, mem_wdata, mem_read, mem_write,
    output mem_rdata, mem_busy, mem_done, mem_err
  );
endinterface

// File: rtl/memory_responder.sv
// Single-outstanding memory responder: latches one request, waits out a fixed
// latency, then accesses a word-addressed RAM and pulses done (and err on a bad op).
module memory_responder #(
  parameter int ADDR_BITS = 9,
  parameter int LATENCY   = 3,
  parameter int WIDTH     = 32
) (
  input logic               clk,
  input logic               clr,
  memory_responder_if.slave bus
);
  localparam int         DEPTH = 1 << ADDR_BITS;
  // Counter runs LATENCY..0 and the access takes one more edge, so done lands
  // LATENCY+1 cycles after the accepting edge.
  localparam logic [3:0] LOAD  = 4'(LATENCY);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_e;
  typedef enum logic [1:0] {OP_RD, OP_WR, OP_BAD}   op_e;

  state_e           state_q, state_d;
  op_e              op_q, op_d;
  logic [3:0]       cnt_q, cnt_d;
  logic [31:0]      addr_q, addr_d;
  logic [WIDTH-1:0] wdata_q, wdata_d;
  logic [WIDTH-1:0] rdata_q, rdata_d;
  logic             err_q, err_d;

  logic [WIDTH-1:0]     ram [DEPTH];
  logic [ADDR_BITS-1:0] idx;
  logic                 oor;
  logic                 access;
  logic                 ram_we;

  assign idx    = addr_q[ADDR_BITS-1:0];
  assign oor    = |addr_q[31:ADDR_BITS];
  assign access = (state_q == S_WAIT) && (cnt_q == 4'd0);
  // clr on the access edge must win over the write
  assign ram_we = access && (op_q == OP_WR) && !oor && !clr;

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    case (state_q)
      S_IDLE: begin
        if (bus.mem_read || bus.mem_write) begin
          state_d = S_WAIT;
          cnt_d   = LOAD;
          addr_d  = bus.mar_addr;
          wdata_d = bus.mem_wdata;
          err_d   = 1'b0;
          if (bus.mem_read && bus.mem_write) op_d = OP_BAD;
          else if (bus.mem_read)             op_d = OP_RD;
          else                               op_d = OP_WR;
        end
      end
      S_WAIT: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          state_d = S_DONE;
          err_d   = (op_q == OP_BAD) || oor;
          if (op_q == OP_RD) rdata_d = oor ? '0 : ram[idx];
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      state_q <= S_IDLE;
      op_q    <= OP_RD;
      cnt_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // RAM has no reset; contents survive clr
  always_ff @(posedge clk) begin
    if (ram_we) ram[idx] <= wdata_q;
  end

  assign bus.mem_rdata = rdata_q;
  assign bus.mem_busy  = (state_q == S_WAIT);
  assign bus.mem_done  = (state_q == S_DONE);
  assign bus.mem_err   = (state_q == S_DONE) && err_q;
endmodule

// File: tb/tb_memory_responder.sv
// Three responders (LATENCY 3, 1, 15) driven by directed and random requests and
// compared every cycle against a cycle-count based behavioural model.
module tb_memory_responder;
  localparam int W  = 32;
  localparam int AB = 9;
  localparam int NI = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        clr [NI];
  logic [31:0] addr [NI];
  logic [W-1:0] wdata [NI];
  logic        rd [NI];
  logic        wr [NI];

  logic [NI-1:0] o_busy, o_done, o_err;
  logic [W-1:0]  o_rdata [NI];

  memory_responder_if #(.WIDTH(W)) bus0 ();
  memory_responder_if #(.WIDTH(W)) bus1 ();
  memory_responder_if #(.WIDTH(W)) bus2 ();

  assign bus0.mar_addr = addr[0]; assign bus0.mem_wdata = wdata[0];
  assign bus0.mem_read = rd[0];   assign bus0.mem_write = wr[0];
  assign bus1.mar_addr = addr[1]; assign bus1.mem_wdata = wdata[1];
  assign bus1.mem_read = rd[1];   assign bus1.mem_write = wr[1];
  assign bus2.mar_addr = addr[2]; assign bus2.mem_wdata = wdata[2];
  assign bus2.mem_read = rd[2];   assign bus2.mem_write = wr[2];

  assign o_busy  = {bus2.mem_busy, bus1.mem_busy, bus0.mem_busy};
  assign o_done  = {bus2.mem_done, bus1.mem_done, bus0.mem_done};
  assign o_err   = {bus2.mem_err,  bus1.mem_err,  bus0.mem_err};
  assign o_rdata[0] = bus0.mem_rdata;
  assign o_rdata[1] = bus1.mem_rdata;
  assign o_rdata[2] = bus2.mem_rdata;

  memory_responder #(.ADDR_BITS(AB), .LATENCY(3),  .WIDTH(W)) u_l3  (.clk(clk), .clr(clr[0]), .bus(bus0.slave));
  memory_responder #(.ADDR_BITS(AB), .LATENCY(1),  .WIDTH(W)) u_l1  (.clk(clk), .clr(clr[1]), .bus(bus1.slave));
  memory_responder #(.ADDR_BITS(AB), .LATENCY(15), .WIDTH(W)) u_l15 (.clk(clk), .clr(clr[2]), .bus(bus2.slave));

  function automatic int unsigned lat_of(input int k);
    case (k)
      0:       return 3;
      1:       return 1;
      default: return 15;
    endcase
  endfunction

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string name, input int k, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s inst%0d (L=%0d) t=%0t got %h expected %h", name, k, lat_of(k), $time, act, exp);
  endtask

  // ---------------- behavioural model ----------------
  // An op accepted at edge A is accessed at edge A+L+1 (done visible after it),
  // and the responder is back to accepting from edge A+L+3 on.
  int unsigned  cyc = 0;
  logic         live [NI];
  logic         pend [NI];
  int unsigned  acc [NI];
  logic         m_rd [NI], m_wr [NI];
  logic [31:0]  m_a [NI];
  logic [W-1:0] m_d [NI];
  logic [W-1:0] mram [NI][512];
  logic         mval [NI][512];
  logic [W-1:0] e_rdata [NI];
  logic         e_rknown [NI], e_busy [NI], e_done [NI], e_err [NI];

  always @(posedge clk) begin : model
    int unsigned  L;
    logic         oor;
    logic [AB-1:0] ix;
    for (int k = 0; k < NI; k++) begin
      L = lat_of(k);
      if (clr[k]) begin
        live[k] = 1'b1; pend[k] = 1'b0;
        e_busy[k] = 1'b0; e_done[k] = 1'b0; e_err[k] = 1'b0;
        e_rdata[k] = '0; e_rknown[k] = 1'b1;
      end else if (live[k]) begin
        e_done[k] = 1'b0; e_err[k] = 1'b0;
        if (pend[k] && cyc == acc[k] + L + 1) begin
          oor = (m_a[k] >> AB) != 0;
          ix  = m_a[k][AB-1:0];
          e_busy[k] = 1'b0; e_done[k] = 1'b1;
          if (m_rd[k] && m_wr[k]) e_err[k] = 1'b1;
          else if (oor) begin
            e_err[k] = 1'b1;
            if (m_rd[k]) begin e_rdata[k] = '0; e_rknown[k] = 1'b1; end
          end else if (m_wr[k]) begin
            mram[k][ix] = m_d[k]; mval[k][ix] = 1'b1;
          end else begin
            e_rdata[k] = mram[k][ix]; e_rknown[k] = mval[k][ix];
          end
        end else if (pend[k] && cyc == acc[k] + L + 2) begin
          pend[k] = 1'b0;
        end else if (!pend[k] && (rd[k] || wr[k])) begin
          pend[k] = 1'b1; acc[k] = cyc;
          m_rd[k] = rd[k]; m_wr[k] = wr[k]; m_a[k] = addr[k]; m_d[k] = wdata[k];
          e_busy[k] = 1'b1;
        end
      end
    end
    cyc++;
  end

  always @(negedge clk) begin : compare
    for (int k = 0; k < NI; k++) begin
      if (live[k]) begin
        chk("busy", k, 32'(o_busy[k]), 32'(e_busy[k]));
        chk("done", k, 32'(o_done[k]), 32'(e_done[k]));
        chk("err",  k, 32'(o_err[k]),  32'(e_err[k]));
        if (e_rknown[k]) chk("rdata", k, o_rdata[k], e_rdata[k]);
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic op(input int k, input logic r, input logic w, input logic [31:0] a,
                    input logic [W-1:0] d, input bit junk,
                    output int lat, output int nbusy, output logic [W-1:0] rdat, output logic er);
    lat = 0; nbusy = 0; rdat = '0; er = 1'b0;
    @(negedge clk); addr[k] = a; wdata[k] = d; rd[k] = r; wr[k] = w;
    @(negedge clk); rd[k] = 1'b0; wr[k] = 1'b0;
    if (o_busy[k]) nbusy++;
    for (int i = 1; i <= 40; i++) begin
      if (junk) begin
        rd[k] = 1'($urandom); wr[k] = 1'($urandom);
        wdata[k] = $urandom; addr[k] = $urandom;
      end
      @(negedge clk);
      if (o_busy[k]) nbusy++;
      if (o_done[k]) begin lat = i; rdat = o_rdata[k]; er = o_err[k]; break; end
    end
    rd[k] = junk; wr[k] = 1'b0;  // a request held during DONE must be ignored
    @(negedge clk); rd[k] = 1'b0;
    chk("latency", k, 32'(lat), 32'(lat_of(k) + 1));
  endtask

  // Start a write, then pulse clr so it is sampled n+1 edges after acceptance.
  task automatic abort_write(input int k, input logic [31:0] a, input logic [W-1:0] d, input int n);
    int ndone;
    ndone = 0;
    @(negedge clk); addr[k] = a; wdata[k] = d; wr[k] = 1'b1;
    @(negedge clk); wr[k] = 1'b0;
    repeat (n) @(negedge clk);
    clr[k] = 1'b1;
    @(negedge clk); clr[k] = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (o_done[k]) ndone++;
      @(negedge clk);
    end
    chk("abort_no_done", k, 32'(ndone), 32'd0);
    chk("abort_idle", k, 32'(o_busy[k]), 32'd0);
  endtask

  task automatic rand_ops(input int k, input int n);
    int lat, nb, s, kind;
    logic [W-1:0] rv;
    logic er;
    logic [31:0] ra;
    for (int a = 0; a < 16; a++) op(k, 1'b0, 1'b1, 32'(a), $urandom, 1'b0, lat, nb, rv, er);
    for (int i = 0; i < n; i++) begin
      s = $urandom_range(0, 9);
      if (s < 8)       ra = 32'($urandom_range(0, 15));
      else if (s == 8) ra = 32'h200 + 32'($urandom_range(0, 63));
      else             ra = 32'h8000_0000 | 32'($urandom_range(0, 15));
      kind = $urandom_range(0, 6);
      op(k, (kind < 3) || (kind == 6), kind >= 3, ra, $urandom, 1'($urandom), lat, nb, rv, er);
    end
  endtask

  initial begin
    int lat, nb;
    logic [W-1:0] rv;
    logic er;
    for (int k = 0; k < NI; k++) begin
      clr[k] = 1'b1; rd[k] = 1'b0; wr[k] = 1'b0; addr[k] = '0; wdata[k] = '0;
      live[k] = 1'b0; pend[k] = 1'b0;
      for (int j = 0; j < 512; j++) begin mram[k][j] = '0; mval[k][j] = 1'b0; end
    end
    repeat (2) @(negedge clk);
    chk("rst_busy",  0, 32'(o_busy[0]), 32'd0);
    chk("rst_done",  0, 32'(o_done[0]), 32'd0);
    chk("rst_err",   0, 32'(o_err[0]),  32'd0);
    chk("rst_rdata", 0, o_rdata[0],     32'd0);
    for (int k = 0; k < NI; k++) clr[k] = 1'b0;

    op(0, 1'b0, 1'b1, 32'h05, 32'hDEADBEEF, 1'b0, lat, nb, rv, er);
    chk("w05_busy_cycles", 0, 32'(nb), 32'd4);
    chk("w05_err", 0, 32'(er), 32'd0);
    op(0, 1'b1, 1'b0, 32'h05, 32'h0, 1'b0, lat, nb, rv, er);
    chk("r05_data", 0, rv, 32'hDEADBEEF);
    chk("r05_err", 0, 32'(er), 32'd0);
    repeat (10) @(negedge clk);
    chk("r05_hold", 0, o_rdata[0], 32'hDEADBEEF);
    op(0, 1'b0, 1'b1, 32'h06, 32'h12345678, 1'b0, lat, nb, rv, er);
    chk("w06_rdata_kept", 0, o_rdata[0], 32'hDEADBEEF);

    op(0, 1'b0, 1'b1, 32'h1FF, 32'h000000AA, 1'b1, lat, nb, rv, er);
    op(0, 1'b1, 1'b0, 32'h1FF, 32'h0, 1'b1, lat, nb, rv, er);
    chk("r1FF_latched", 0, rv, 32'h000000AA);

    op(0, 1'b1, 1'b0, 32'h200, 32'h0, 1'b0, lat, nb, rv, er);
    chk("r200_err", 0, 32'(er), 32'd1);
    chk("r200_data", 0, rv, 32'd0);
    op(0, 1'b0, 1'b1, 32'h205, 32'h55, 1'b0, lat, nb, rv, er);
    chk("w205_err", 0, 32'(er), 32'd1);
    op(0, 1'b1, 1'b0, 32'h05, 32'h0, 1'b0, lat, nb, rv, er);
    chk("r05_after_oor", 0, rv, 32'hDEADBEEF);
    op(0, 1'b1, 1'b1, 32'h05, 32'h0, 1'b0, lat, nb, rv, er);
    chk("both_err", 0, 32'(er), 32'd1);
    op(0, 1'b1, 1'b0, 32'h05, 32'h0, 1'b0, lat, nb, rv, er);
    chk("r05_after_both", 0, rv, 32'hDEADBEEF);

    op(0, 1'b0, 1'b1, 32'h10, 32'h0, 1'b0, lat, nb, rv, er);
    abort_write(0, 32'h10, 32'hCAFEF00D, 0);
    op(0, 1'b1, 1'b0, 32'h10, 32'h0, 1'b0, lat, nb, rv, er);
    chk("r10_after_abort", 0, rv, 32'd0);
    op(0, 1'b1, 1'b0, 32'h05, 32'h0, 1'b0, lat, nb, rv, er);
    chk("r05_ram_kept", 0, rv, 32'hDEADBEEF);
    op(0, 1'b0, 1'b1, 32'h11, 32'h0, 1'b0, lat, nb, rv, er);
    abort_write(0, 32'h11, 32'h0BADCAFE, 3);
    op(0, 1'b1, 1'b0, 32'h11, 32'h0, 1'b0, lat, nb, rv, er);
    chk("r11_clr_at_access", 0, rv, 32'd0);

    op(1, 1'b0, 1'b1, 32'h07, 32'h0BADF00D, 1'b0, lat, nb, rv, er);
    op(1, 1'b1, 1'b0, 32'h07, 32'h0, 1'b0, lat, nb, rv, er);
    chk("l1_lat", 1, 32'(lat), 32'd2);
    chk("l1_data", 1, rv, 32'h0BADF00D);
    op(2, 1'b0, 1'b1, 32'h07, 32'h600DF00D, 1'b0, lat, nb, rv, er);
    op(2, 1'b1, 1'b0, 32'h07, 32'h0, 1'b0, lat, nb, rv, er);
    chk("l15_lat", 2, 32'(lat), 32'd16);
    chk("l15_data", 2, rv, 32'h600DF00D);

    fork
      rand_ops(0, 150);
      rand_ops(1, 150);
      rand_ops(2, 100);
    join
    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
